// File: rtl/buf_io_pkg.sv
// Shared helpers for the bidirectional pad bank.
// Counter sizing and parameter legality live here.
package buf_io_pkg;

  function automatic int cnt_w(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  function automatic bit params_ok(
    input int sync_stages,
    input int filt_len
  );
    return (sync_stages >= 2) && (filt_len >= 1);
  endfunction

endpackage

// File: rtl/buf_io_filt.sv
// One pad channel: synchroniser, persistence filter,
// filtered level and registered edge strobes.
module buf_io_filt
  import buf_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter bit MASK_DRV    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  input  logic oe,
  output logic o,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(FILT_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   s;
  logic                   mask;

  assign s    = sync_q[SYNC_STAGES-1];
  assign mask = MASK_DRV & oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      o      <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (s == o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        // level persisted long enough; commit it
        o     <= s;
        cnt_q <= '0;
        rise  <= s & ~mask;
        fall  <= ~s & ~mask;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/buf_io_bank.sv
// WIDTH-channel bidirectional pad bank with registered drive
// and filtered, edge-reporting input path.
module buf_io_bank
  import buf_io_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter bit MASK_DRV    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] I,
  inout  wire  [WIDTH-1:0] IO,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  if (!params_ok(SYNC_STAGES, FILT_LEN)) begin : g_bad_params
    $error("buf_io_bank: need SYNC_STAGES>=2, FILT_LEN>=1");
  end

  logic [WIDTH-1:0] i_q;
  logic [WIDTH-1:0] oe_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      i_q  <= '0;
      oe_q <= '0;
    end else begin
      i_q  <= I;
      oe_q <= ~T;
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    assign IO[n] = oe_q[n] ? i_q[n] : 1'bz;

    buf_io_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .MASK_DRV   (MASK_DRV)
    ) u_filt (
      .clk  (CLK),
      .rst_n(RST_N),
      .pad  (IO[n]),
      .oe   (oe_q[n]),
      .o    (O[n]),
      .rise (RISE[n]),
      .fall (FALL[n])
    );
  end

endmodule

// File: tb/tb_buf_io_bank.sv
// Directed bench for buf_io_bank: default, unmasked and
// FILT_LEN=1 builds share stimulus and external pad drivers.
module tb_buf_io_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] t = 4'h0;
  logic [3:0] i = 4'hF;
  logic [3:0] ext_en = 4'b1110;
  logic [3:0] ext_val = 4'h0;

  wire  [3:0] io_a, io_b, io_c;
  logic [3:0] o_a, rise_a, fall_a;
  logic [3:0] o_b, rise_b, fall_b;
  logic [3:0] o_c, rise_c, fall_c;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_ext
    assign io_a[k] = ext_en[k] ? ext_val[k] : 1'bz;
    assign io_b[k] = ext_en[k] ? ext_val[k] : 1'bz;
    assign io_c[k] = ext_en[k] ? ext_val[k] : 1'bz;
  end

  buf_io_bank #(
    .WIDTH(4), .SYNC_STAGES(2), .FILT_LEN(4), .MASK_DRV(1'b1)
  ) u_a (
    .CLK(clk), .RST_N(rst_n), .T(t), .I(i), .IO(io_a),
    .O(o_a), .RISE(rise_a), .FALL(fall_a)
  );

  buf_io_bank #(
    .WIDTH(4), .SYNC_STAGES(2), .FILT_LEN(4), .MASK_DRV(1'b0)
  ) u_b (
    .CLK(clk), .RST_N(rst_n), .T(t), .I(i), .IO(io_b),
    .O(o_b), .RISE(rise_b), .FALL(fall_b)
  );

  buf_io_bank #(
    .WIDTH(4), .SYNC_STAGES(2), .FILT_LEN(1), .MASK_DRV(1'b1)
  ) u_c (
    .CLK(clk), .RST_N(rst_n), .T(t), .I(i), .IO(io_c),
    .O(o_c), .RISE(rise_c), .FALL(fall_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t = 4'h0;
    i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (io_a[3:1] !== 3'b000 || io_a[0] === 1'b1)
        $display("FAIL reset_io got=%b exp=zzz0/000z", io_a);
      else passed++;
      total++;
      if ({o_a, rise_a, fall_a} !== 12'h000)
        $display("FAIL reset_out got=%h exp=000",
                 {o_a, rise_a, fall_a});
      else passed++;
      total++;
      if ({o_b, o_c} !== 8'h00)
        $display("FAIL reset_o_bc got=%h exp=00", {o_b, o_c});
      else passed++;
    end
  endtask

  task automatic test_drive_mask();
    int nra;
    rst_n = 1'b1;
    t = 4'b1110;
    i = 4'b0001;
    step();
    total++;
    if (io_a !== 4'b0001)
      $display("FAIL drive_io got=%b exp=0001", io_a);
    else passed++;
    nra = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (rise_a[0]) nra++;
      if (k == 2) begin
        total++;
        if (o_c[0] !== 1'b0)
          $display("FAIL f1_o_early got=%b exp=0", o_c[0]);
        else passed++;
      end
      if (k == 3) begin
        total++;
        if (o_c[0] !== 1'b1)
          $display("FAIL f1_o_drv got=%b exp=1", o_c[0]);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if ({o_a[0], o_b[0]} !== 2'b00)
          $display("FAIL drive_o_early got=%b exp=00",
                   {o_a[0], o_b[0]});
        else passed++;
      end
      if (k == 6) begin
        total++;
        if ({o_a[0], rise_a[0]} !== 2'b10)
          $display("FAIL drive_masked got=%b exp=10",
                   {o_a[0], rise_a[0]});
        else passed++;
        total++;
        if ({o_b[0], rise_b[0]} !== 2'b11)
          $display("FAIL drive_unmasked got=%b exp=11",
                   {o_b[0], rise_b[0]});
        else passed++;
      end
      if (k == 7) begin
        total++;
        if (rise_b[0] !== 1'b0)
          $display("FAIL unmasked_len got=%b exp=0", rise_b[0]);
        else passed++;
      end
    end
    total++;
    if (nra != 0)
      $display("FAIL masked_rise_cnt got=%0d exp=0", nra);
    else passed++;
  endtask

  task automatic test_glitch();
    int nr;
    nr = 0;
    ext_val[1] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 3) ext_val[1] = 1'b0;
      if (rise_a[1]) nr++;
    end
    total++;
    if (o_a[1] !== 1'b0)
      $display("FAIL glitch_o got=%b exp=0", o_a[1]);
    else passed++;
    total++;
    if (nr != 0)
      $display("FAIL glitch_rise got=%0d exp=0", nr);
    else passed++;
  endtask

  task automatic test_accept();
    int nr;
    int nf;
    nr = 0;
    ext_val[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise_a[1]) nr++;
      if (k == 5) begin
        total++;
        if (o_a[1] !== 1'b0)
          $display("FAIL accept_early got=%b exp=0", o_a[1]);
        else passed++;
      end
      if (k == 6) begin
        total++;
        if ({o_a[1], rise_a[1]} !== 2'b11)
          $display("FAIL accept_rise got=%b exp=11",
                   {o_a[1], rise_a[1]});
        else passed++;
      end
    end
    total++;
    if (nr != 1)
      $display("FAIL accept_rise_cnt got=%0d exp=1", nr);
    else passed++;
    nf = 0;
    ext_val[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (fall_a[1]) nf++;
      if (k == 5) begin
        total++;
        if ({o_a[1], fall_a[1]} !== 2'b10)
          $display("FAIL drop_early got=%b exp=10",
                   {o_a[1], fall_a[1]});
        else passed++;
      end
      if (k == 6) begin
        total++;
        if ({o_a[1], fall_a[1]} !== 2'b01)
          $display("FAIL drop_fall got=%b exp=01",
                   {o_a[1], fall_a[1]});
        else passed++;
      end
    end
    total++;
    if (nf != 1)
      $display("FAIL drop_fall_cnt got=%0d exp=1", nf);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int nr;
    ext_val[2] = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    total++;
    if (o_a[0] !== 1'b1)
      $display("FAIL pre_rst_o got=%b exp=1", o_a[0]);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_a, rise_a, fall_a} !== 12'h000)
      $display("FAIL mid_rst_out got=%h exp=000",
               {o_a, rise_a, fall_a});
    else passed++;
    total++;
    if (io_a[0] === 1'b1)
      $display("FAIL mid_rst_io got=%b exp=z", io_a[0]);
    else passed++;
    #2;
    rst_n = 1'b1;
    nr = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise_a[2]) nr++;
      if (k == 1) begin
        total++;
        if (io_a[0] !== 1'b1)
          $display("FAIL post_rst_io got=%b exp=1", io_a[0]);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if (o_a[2] !== 1'b0)
          $display("FAIL post_rst_early got=%b exp=0", o_a[2]);
        else passed++;
      end
      if (k == 6) begin
        total++;
        if ({o_a[2], rise_a[2]} !== 2'b11)
          $display("FAIL post_rst_rise got=%b exp=11",
                   {o_a[2], rise_a[2]});
        else passed++;
      end
    end
    total++;
    if (nr != 1)
      $display("FAIL post_rst_cnt got=%0d exp=1", nr);
    else passed++;
  endtask

  task automatic test_filt1();
    ext_val[3] = 1'b1;
    step();
    ext_val[3] = 1'b0;
    step();
    total++;
    if (o_c[3] !== 1'b0)
      $display("FAIL f1_pre got=%b exp=0", o_c[3]);
    else passed++;
    step();
    total++;
    if ({o_c[3], rise_c[3], fall_c[3]} !== 3'b110)
      $display("FAIL f1_rise got=%b exp=110",
               {o_c[3], rise_c[3], fall_c[3]});
    else passed++;
    step();
    total++;
    if ({o_c[3], rise_c[3], fall_c[3]} !== 3'b001)
      $display("FAIL f1_fall got=%b exp=001",
               {o_c[3], rise_c[3], fall_c[3]});
    else passed++;
    step();
    total++;
    if ({fall_c[3], o_a[3]} !== 2'b00)
      $display("FAIL f1_after got=%b exp=00",
               {fall_c[3], o_a[3]});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_drive_mask();
    test_glitch();
    test_accept();
    test_reset_mid();
    test_filt1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
